// File: rtl/cb_dbuf_cfg.sv
// -----------------------------------------------------------------------------
// cb_dbuf_cfg
//
// Connection block with double-buffered configuration memory. Each of NUM_PINS
// grid-pin multiplexers picks one of MUX_SIZE channel tracks. Selects are
// written one bit at a time into a shadow bank. A commit copies the shadow
// bank into the active bank one pin per cycle, so a pin only ever switches
// between two complete selects. Channel tracks pass straight through.
//
// Ports
//   prog_clk     configuration / state clock
//   pReset       asynchronous active-high reset
//   chanx_in     channel tracks in
//   chanx_out    channel tracks out (combinational pass-through)
//   grid_pin     mux outputs, combinational from active bank and chanx_in
//   cfg_en       shadow write strobe (IDLE only)
//   cfg_addr     {pin index, bit index}, pin index in the MSBs
//   cfg_data     bit value to write
//   cfg_commit   start a shadow -> active copy
//   cfg_rd_en    readback strobe
//   cfg_rd_sel   readback bank: 0 = shadow, 1 = active
//   cfg_rd_data  registered readback bit
//   cfg_busy     copy in progress
//   cfg_done     one-cycle pulse when a copy finishes
//   cfg_err      sticky error flag, cleared only by pReset
//
// Input i of pin p is track (p*PIN_STRIDE + i*IN_STRIDE) mod CHAN_W.
// Select 0 disconnects the pin, select s in 1..MUX_SIZE picks input s-1,
// and any larger select also drives 0.
// -----------------------------------------------------------------------------
module cb_dbuf_cfg #(
  parameter  int CHAN_W     = 18,
  parameter  int NUM_PINS   = 11,
  parameter  int MUX_SIZE   = 6,
  parameter  int PIN_STRIDE = 2,
  parameter  int IN_STRIDE  = 3,
  localparam int SEL_W      = $clog2(MUX_SIZE + 1),
  localparam int PIN_AW     = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1,
  localparam int BIT_AW     = (SEL_W > 1) ? $clog2(SEL_W) : 1
) (
  input  logic                     prog_clk,
  input  logic                     pReset,
  input  logic [CHAN_W-1:0]        chanx_in,
  output logic [CHAN_W-1:0]        chanx_out,
  output logic [NUM_PINS-1:0]      grid_pin,
  input  logic                     cfg_en,
  input  logic [PIN_AW+BIT_AW-1:0] cfg_addr,
  input  logic                     cfg_data,
  input  logic                     cfg_commit,
  input  logic                     cfg_rd_en,
  input  logic                     cfg_rd_sel,
  output logic                     cfg_rd_data,
  output logic                     cfg_busy,
  output logic                     cfg_done,
  output logic                     cfg_err
);

  // Both banks are stored flat: pin p occupies bits [p*SEL_W +: SEL_W].
  localparam int CFG_BITS = NUM_PINS * SEL_W;
  localparam int IDX_W    = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

  localparam logic [PIN_AW-1:0] LAST_PIN = PIN_AW'(NUM_PINS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    COPY = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q,   state_d;
  logic [PIN_AW-1:0]   cnt_q,     cnt_d;
  logic [CFG_BITS-1:0] shadow_q,  shadow_d;
  logic [CFG_BITS-1:0] active_q,  active_d;
  logic                done_q,    done_d;
  logic                err_q,     err_d;
  logic                rd_data_q, rd_data_d;

  // ---------------------------------------------------------------------------
  // Address decode, shared by write and readback
  // ---------------------------------------------------------------------------
  logic [PIN_AW-1:0]   addr_pin;
  logic [BIT_AW-1:0]   addr_bit;
  logic                addr_ok;
  logic [IDX_W-1:0]    addr_idx;
  logic [CFG_BITS-1:0] addr_mask;
  logic [IDX_W-1:0]    copy_idx;
  logic [CFG_BITS-1:0] copy_mask;
  logic [CFG_BITS-1:0] rd_bank;

  assign addr_pin = cfg_addr[PIN_AW+BIT_AW-1 -: PIN_AW];
  assign addr_bit = cfg_addr[BIT_AW-1:0];

  // Compare one bit wider than the field so a power-of-two bound does not
  // wrap to zero.
  assign addr_ok = ({1'b0, addr_pin} < (PIN_AW+1)'(NUM_PINS)) &&
                   ({1'b0, addr_bit} < (BIT_AW+1)'(SEL_W));

  // For an out-of-range address the index is meaningless, but every consumer
  // of addr_mask is qualified by addr_ok.
  assign addr_idx  = IDX_W'(addr_pin) * IDX_W'(SEL_W) + IDX_W'(addr_bit);
  assign addr_mask = CFG_BITS'(1) << addr_idx;

  // Field of the pin currently being copied.
  assign copy_idx  = IDX_W'(cnt_q) * IDX_W'(SEL_W);
  assign copy_mask = CFG_BITS'({SEL_W{1'b1}}) << copy_idx;

  assign rd_bank   = cfg_rd_sel ? active_q : shadow_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    done_d    = 1'b0;
    err_d     = err_q;
    rd_data_d = rd_data_q;

    case (state_q)
      IDLE: begin
        if (cfg_en && addr_ok) begin
          shadow_d = (shadow_q & ~addr_mask) | (cfg_data ? addr_mask : '0);
        end
        // A write in this same cycle lands in shadow_q before the first copy
        // cycle reads it, so the copy includes it.
        if (cfg_commit) begin
          state_d = COPY;
          cnt_d   = '0;
        end
      end

      COPY: begin
        active_d = (active_q & ~copy_mask) | (shadow_q & copy_mask);
        if (cnt_q == LAST_PIN) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + PIN_AW'(1);
        end
        // cfg_commit is ignored here and is not an error.
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Writes are dropped while copying or when out of range.
    if (cfg_en && ((state_q == COPY) || !addr_ok)) begin
      err_d = 1'b1;
    end

    // Readback samples the current (pre-write) bank contents, so a read and
    // write to the same shadow bit in one cycle returns the old value.
    if (cfg_rd_en) begin
      if (addr_ok) begin
        rd_data_d = |(rd_bank & addr_mask);
      end else begin
        rd_data_d = 1'b0;
        err_d     = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: both configuration banks sit in the asynchronous reset. Unlike a
  // data RAM they drive routing directly, so a reset must leave every pin
  // disconnected rather than holding stale or unknown selects.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the values from before this edge regardless of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= rd_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign chanx_out   = chanx_in;
  // Decoded from the state register, so an asynchronous reset drops it at once.
  assign cfg_busy    = (state_q == COPY);
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;
  assign cfg_rd_data = rd_data_q;

  // ---------------------------------------------------------------------------
  // Grid-pin multiplexers: AND-OR of one-hot select decode against the taps.
  // Selects of 0 or above MUX_SIZE match no tap and yield 0.
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
    logic [SEL_W-1:0]    sel;
    logic [MUX_SIZE-1:0] taps;
    logic [MUX_SIZE-1:0] hit;

    assign sel = active_q[p*SEL_W +: SEL_W];

    for (genvar i = 0; i < MUX_SIZE; i++) begin : g_in
      assign taps[i] = chanx_in[(p*PIN_STRIDE + i*IN_STRIDE) % CHAN_W];
      assign hit[i]  = (sel == SEL_W'(i + 1));
    end

    assign grid_pin[p] = |(taps & hit);
  end

endmodule

// File: tb/tb_cb_dbuf_cfg.sv
// -----------------------------------------------------------------------------
// tb_cb_dbuf_cfg
//
// Directed bench for cb_dbuf_cfg with default parameters
// (CHAN_W=18, NUM_PINS=11, MUX_SIZE=6, SEL_W=3, PIN_AW=4, BIT_AW=2).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_cb_dbuf_cfg;

  localparam int CHAN_W   = 18;
  localparam int NUM_PINS = 11;

  logic                prog_clk = 1'b0;
  logic                pReset;
  logic [CHAN_W-1:0]   chanx_in;
  logic [CHAN_W-1:0]   chanx_out;
  logic [NUM_PINS-1:0] grid_pin;
  logic                cfg_en;
  logic [5:0]          cfg_addr;
  logic                cfg_data;
  logic                cfg_commit;
  logic                cfg_rd_en;
  logic                cfg_rd_sel;
  logic                cfg_rd_data;
  logic                cfg_busy;
  logic                cfg_done;
  logic                cfg_err;

  int n_pass  = 0;
  int n_total = 0;

  cb_dbuf_cfg dut (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .chanx_in    (chanx_in),
    .chanx_out   (chanx_out),
    .grid_pin    (grid_pin),
    .cfg_en      (cfg_en),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_commit  (cfg_commit),
    .cfg_rd_en   (cfg_rd_en),
    .cfg_rd_sel  (cfg_rd_sel),
    .cfg_rd_data (cfg_rd_data),
    .cfg_busy    (cfg_busy),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err)
  );

  initial forever #5 prog_clk = ~prog_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  function automatic logic [5:0] mk_addr(input int pin, input int b);
    return {4'(pin), 2'(b)};
  endfunction

  task automatic write_bit(input int pin, input int b, input logic v);
    cfg_en   = 1'b1;
    cfg_addr = mk_addr(pin, b);
    cfg_data = v;
    tick();
    cfg_en   = 1'b0;
    cfg_data = 1'b0;
  endtask

  // Writes a 3-bit select LSB first.
  task automatic write_sel(input int pin, input int sel);
    for (int b = 0; b < 3; b++) write_bit(pin, b, 1'((sel >> b) & 1));
  endtask

  task automatic read_bit(input int pin, input int b, input logic bank, output logic v);
    cfg_addr   = mk_addr(pin, b);
    cfg_rd_sel = bank;
    cfg_rd_en  = 1'b1;
    tick();
    cfg_rd_en  = 1'b0;
    v = cfg_rd_data;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic wait_done(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (cfg_done) seen = 1'b1;
    end
  endtask

  // Pulse reset between edges and realign to just after the next edge.
  task automatic do_reset();
    #2 pReset = 1'b1;
    #2 pReset = 1'b0;
    tick();
  endtask

  initial begin
    logic v;
    logic seen;
    int   busy_cnt;
    int   done_cnt;

    pReset     = 1'b1;
    chanx_in   = '0;
    cfg_en     = 1'b0;
    cfg_addr   = '0;
    cfg_data   = 1'b0;
    cfg_commit = 1'b0;
    cfg_rd_en  = 1'b0;
    cfg_rd_sel = 1'b0;

    // ---- Reset with toggling channel inputs --------------------------------
    for (int i = 0; i < 4; i++) begin
      chanx_in = CHAN_W'($urandom);
      #3;
      check($sformatf("rst_grid_%0d", i), 32'(grid_pin), 0);
      check($sformatf("rst_pass_%0d", i), 32'(chanx_out), 32'(chanx_in));
    end
    check("rst_busy", 32'(cfg_busy), 0);
    check("rst_err",  32'(cfg_err), 0);
    check("rst_done", 32'(cfg_done), 0);
    check("rst_rd",   32'(cfg_rd_data), 0);
    @(negedge prog_clk);
    pReset = 1'b0;
    tick();

    // ---- Pin 5 select 4 -> track 1; commit timing --------------------------
    chanx_in = '1;
    write_sel(5, 4);
    check("p5_pre_commit", 32'(grid_pin), 0);
    commit();                            // edge T
    busy_cnt = cfg_busy ? 1 : 0;
    done_cnt = cfg_done ? 1 : 0;
    check("p5_busy_k0", 32'(cfg_busy), 1);
    check("p5_grid_k0", 32'(grid_pin[5]), 0);
    for (int k = 1; k <= 13; k++) begin  // now just after edge T+k
      tick();
      if (cfg_busy) busy_cnt++;
      if (cfg_done) done_cnt++;
      check($sformatf("p5_busy_k%0d", k), 32'(cfg_busy), 32'(k <= 10));
      check($sformatf("p5_done_k%0d", k), 32'(cfg_done), 32'(k == 11));
      check($sformatf("p5_grid_k%0d", k), 32'(grid_pin[5]), 32'(k >= 6));
    end
    check("p5_busy_cycles", busy_cnt, 11);
    check("p5_done_pulses", done_cnt, 1);
    chanx_in = 18'h00002; #1;
    check("p5_track1_hi", 32'(grid_pin), 32'h020);
    chanx_in = 18'h3fffd; #1;
    check("p5_track1_lo", 32'(grid_pin), 32'h000);
    check("p5_err", 32'(cfg_err), 0);

    // ---- Pin 1 select 3 without commit, then with commit -------------------
    chanx_in = '1;
    write_sel(1, 3);
    read_bit(1, 0, 1'b0, v); check("p1_sh_b0", 32'(v), 1);
    read_bit(1, 1, 1'b0, v); check("p1_sh_b1", 32'(v), 1);
    read_bit(1, 2, 1'b0, v); check("p1_sh_b2", 32'(v), 0);
    read_bit(1, 0, 1'b1, v); check("p1_ac_b0", 32'(v), 0);
    read_bit(1, 1, 1'b1, v); check("p1_ac_b1", 32'(v), 0);
    read_bit(1, 2, 1'b1, v); check("p1_ac_b2", 32'(v), 0);
    check("p1_grid_uncommitted", 32'(grid_pin), 32'h020);
    // Readback holds while cfg_rd_en is low.
    read_bit(1, 0, 1'b0, v);
    tick(); tick();
    check("rd_hold", 32'(cfg_rd_data), 1);
    // Commit, with a second commit pulse mid-copy that must be ignored.
    commit();
    tick(); tick();
    commit();
    wait_done(seen);
    check("p1_done_seen", 32'(seen), 1);
    tick();
    check("p1_no_recommit", 32'(cfg_busy), 0);
    check("p1_recommit_no_err", 32'(cfg_err), 0);
    chanx_in = 18'h00100; #1;
    check("p1_track8", 32'(grid_pin), 32'h002);
    chanx_in = 18'h00102; #1;
    check("p1_p5_tracks", 32'(grid_pin), 32'h022);
    read_bit(1, 1, 1'b1, v); check("p1_ac_after", 32'(v), 1);

    // Read and write the same shadow bit in one cycle: old value returned.
    cfg_en = 1'b1; cfg_rd_en = 1'b1; cfg_rd_sel = 1'b0;
    cfg_addr = mk_addr(3, 0); cfg_data = 1'b1;
    tick();
    cfg_en = 1'b0; cfg_rd_en = 1'b0; cfg_data = 1'b0;
    check("rw_same_old", 32'(cfg_rd_data), 0);
    read_bit(3, 0, 1'b0, v); check("rw_same_new", 32'(v), 1);

    // ---- Errors ------------------------------------------------------------
    do_reset();
    check("err_after_rst", 32'(cfg_err), 0);
    write_bit(11, 0, 1'b1);
    check("err_pin11", 32'(cfg_err), 1);
    read_bit(10, 2, 1'b0, v); check("pin11_no_alias_p10b2", 32'(v), 0);
    read_bit(0, 0, 1'b0, v);  check("pin11_no_alias_p0b0", 32'(v), 0);

    do_reset();
    write_bit(0, 3, 1'b1);
    check("err_bit3", 32'(cfg_err), 1);
    read_bit(1, 0, 1'b0, v); check("bit3_no_alias", 32'(v), 0);

    do_reset();
    write_bit(2, 1, 1'b1);
    read_bit(2, 1, 1'b0, v); check("rd_valid_one", 32'(v), 1);
    check("rd_valid_no_err", 32'(cfg_err), 0);
    read_bit(12, 0, 1'b0, v); check("rd_oor_zero", 32'(v), 0);
    check("err_rd_oor", 32'(cfg_err), 1);

    do_reset();
    commit();
    tick();
    write_bit(2, 0, 1'b1);
    check("err_wr_copy", 32'(cfg_err), 1);
    wait_done(seen);
    check("wr_copy_done", 32'(seen), 1);
    read_bit(2, 0, 1'b0, v); check("wr_copy_dropped", 32'(v), 0);

    do_reset();
    chanx_in = '1;
    write_sel(0, 7);
    commit();
    wait_done(seen);
    check("sel7_done", 32'(seen), 1);
    check("sel7_grid", 32'(grid_pin), 0);
    check("sel7_no_err", 32'(cfg_err), 0);

    // ---- Write and commit in the same cycle: pin 0 select 1 -> track 0 -----
    do_reset();
    chanx_in   = '1;
    cfg_en     = 1'b1;
    cfg_addr   = mk_addr(0, 0);
    cfg_data   = 1'b1;
    cfg_commit = 1'b1;
    tick();                              // edge T
    cfg_en = 1'b0; cfg_data = 1'b0; cfg_commit = 1'b0;
    check("wc_grid_T", 32'(grid_pin), 0);
    tick();                              // edge T+1
    check("wc_grid_T1", 32'(grid_pin), 32'h001);
    chanx_in = 18'h3fffe; #1;
    check("wc_track0_lo", 32'(grid_pin), 0);
    chanx_in = 18'h00001; #1;
    check("wc_track0_hi", 32'(grid_pin), 32'h001);
    wait_done(seen);
    check("wc_done", 32'(seen), 1);

    // ---- Reset in the middle of a copy -------------------------------------
    chanx_in = '1;
    write_sel(5, 4);
    commit();                            // edge T
    for (int k = 0; k < 4; k++) tick();  // just after edge T+4
    check("mid_busy_before", 32'(cfg_busy), 1);
    #2 pReset = 1'b1;
    #1;
    check("mid_busy_async", 32'(cfg_busy), 0);
    check("mid_grid_async", 32'(grid_pin), 0);
    #2 pReset = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (cfg_done) done_cnt++;
    end
    check("mid_no_done", done_cnt, 0);
    check("mid_grid_idle", 32'(grid_pin), 0);
    read_bit(0, 0, 1'b1, v); check("mid_active_p0", 32'(v), 0);
    read_bit(5, 2, 1'b0, v); check("mid_shadow_p5", 32'(v), 0);
    write_sel(5, 4);
    commit();
    wait_done(seen);
    check("mid_fresh_done", 32'(seen), 1);
    check("mid_fresh_grid", 32'(grid_pin), 32'h020);
    check("mid_fresh_err", 32'(cfg_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
